// File: rtl/sqrt_stream_ctrl_if.sv
// Bundle of the operand stream, result stream, engine and error signals
// of sqrt_stream_ctrl. master = surrounding pipeline/engine side, slave = controller.
interface sqrt_stream_ctrl_if #(
    parameter int unsigned W = 16
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         eng_start;
    logic [W-1:0] eng_din;
    logic         eng_busy;
    logic [W-1:0] eng_dout;
    logic         err_clr;
    logic         err;

    modport master (
        output in_valid, in_data, out_ready, eng_busy, eng_dout, err_clr,
        input  in_ready, out_valid, out_data, eng_start, eng_din, err
    );

    modport slave (
        input  in_valid, in_data, out_ready, eng_busy, eng_dout, err_clr,
        output in_ready, out_valid, out_data, eng_start, eng_din, err
    );
endinterface

// File: rtl/sqrt_stream_ctrl.sv
// Stream initiator for start/busy sequential engines: accepts one operand at a
// time, kicks the engine, waits for busy to fall (with a hang watchdog) and
// queues results in a 2-entry FIFO.
module sqrt_stream_ctrl #(
    parameter int unsigned W     = 16,
    parameter int unsigned TMO_W = 6
) (
    input logic               clk,
    input logic               rst,
    sqrt_stream_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, KICK, WAIT} state_t;

    localparam logic [TMO_W-1:0] TMO_MAX = '1;

    state_t           state;
    logic             wait_first;
    logic [TMO_W-1:0] wdog;
    logic             eng_start_r;
    logic [W-1:0]     eng_din_r;
    logic             err_r;

    logic [1:0]       fcount;
    logic             rd_ptr;
    logic [W-1:0]     mem [2];

    logic             in_ready_w;
    logic             out_valid_w;
    logic             accept;
    logic             done;
    logic             timeout;
    logic             push;
    logic             pop;
    logic             wr_ptr;

    // Handshake decode and completion/timeout detection
    always_comb begin
        in_ready_w  = 1'b0;
        out_valid_w = 1'b0;
        accept      = 1'b0;
        done        = 1'b0;
        timeout     = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        wr_ptr      = 1'b0;

        in_ready_w  = (state == IDLE) && !bus.eng_busy && (fcount < 2'd2);
        out_valid_w = (fcount != 2'd0);
        accept      = bus.in_valid && in_ready_w;
        // busy is ignored in the first WAIT cycle: the engine raises it one cycle after start
        done        = (state == WAIT) && !wait_first && !bus.eng_busy;
        timeout     = (state == WAIT) && !wait_first && bus.eng_busy && (wdog == TMO_MAX);
        push        = done;
        pop         = out_valid_w && bus.out_ready;
        // tail slot: head when empty or full, the other slot when one entry is held
        wr_ptr      = rd_ptr ^ fcount[0];
    end

    // Control FSM with registered engine kick/operand and watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_first  <= 1'b0;
            wdog        <= '0;
            eng_start_r <= 1'b0;
            eng_din_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    eng_start_r <= 1'b0;
                    if (accept) begin
                        eng_din_r   <= bus.in_data;
                        eng_start_r <= 1'b1;
                        state       <= KICK;
                    end
                end
                KICK: begin
                    eng_start_r <= 1'b0;
                    wdog        <= '0;
                    wait_first  <= 1'b1;
                    state       <= WAIT;
                end
                WAIT: begin
                    eng_start_r <= 1'b0;
                    if (wait_first) begin
                        wait_first <= 1'b0;
                        wdog       <= wdog + TMO_W'(1);
                    end else if (done || timeout) begin
                        state <= IDLE;
                    end else begin
                        wdog <= wdog + TMO_W'(1);
                    end
                end
                default: begin
                    eng_start_r <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // Result FIFO: storage, read pointer and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            fcount <= '0;
            rd_ptr <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.eng_dout;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fcount <= fcount + 2'd1;
                2'b01:   fcount <= fcount - 2'd1;
                default: fcount <= fcount;
            endcase
        end
    end

    // Sticky watchdog error; a timeout wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (timeout) begin
            err_r <= 1'b1;
        end else if (bus.err_clr) begin
            err_r <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = mem[rd_ptr];
    assign bus.eng_start = eng_start_r;
    assign bus.eng_din   = eng_din_r;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_sqrt_stream_ctrl.sv
// Directed and randomized checks of sqrt_stream_ctrl against a behavioural
// engine (busy for B cycles after start, result = operand + 1) and a result queue.
module tb_sqrt_stream_ctrl;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sqrt_stream_ctrl_if #(.W(16)) bus ();

    sqrt_stream_ctrl #(.W(16), .TMO_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural engine
    int unsigned eng_b      = 5;
    logic        hold_busy  = 1'b0;
    int unsigned rem        = 0;
    logic        eng_busy_m = 1'b0;
    logic [15:0] eng_dout_m = '0;

    assign bus.eng_busy = eng_busy_m;
    assign bus.eng_dout = eng_dout_m;

    always @(posedge clk) begin
        if (bus.eng_start) begin
            rem        <= eng_b;
            eng_busy_m <= 1'b1;
            eng_dout_m <= bus.eng_din + 16'd1;
        end else if (rem > 1) begin
            rem <= rem - 1;
        end else begin
            rem        <= 0;
            eng_busy_m <= hold_busy;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Present an operand until it is accepted; returns in the KICK cycle
    task automatic send(input logic [15:0] d, input string tag);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200 && !bus.in_ready; i++) cyc();
        chk({tag, "_accept"}, 32'(bus.in_ready), 32'd1);
        cyc();
        bus.in_valid = 1'b0;
    endtask

    logic [15:0] expq[$];

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;
        bus.err_clr  = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_eng_start", 32'(bus.eng_start), 32'd0);
        chk("rst_eng_din",   32'(bus.eng_din),   32'd0);
        chk("rst_err",       32'(bus.err),       32'd0);
        chk("rst_fcount",    32'(dut.fcount),    32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);

        // 1: single operation, latency B+3 from accept to out_valid
        eng_b = 5;
        send(16'h4000, "t1");
        chk("t1_start_hi", 32'(bus.eng_start), 32'd1);
        chk("t1_eng_din",  32'(bus.eng_din),   32'h4000);
        chk("t1_busy_rdy", 32'(bus.in_ready),  32'd0);
        cyc();
        for (int i = 0; i <= 5; i++) begin
            chk("t1_start_lo", 32'(bus.eng_start), 32'd0);
            chk("t1_early_ov", 32'(bus.out_valid), 32'd0);
            cyc();
        end
        chk("t1_ov",   32'(bus.out_valid), 32'd1);
        chk("t1_data", 32'(bus.out_data),  32'h4001);
        bus.out_ready = 1'b1;
        cyc();
        chk("t1_popped", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        // 2: fill FIFO, stall input, drain in order
        send(16'h0001, "t2a");
        send(16'h0100, "t2b");
        repeat (7) cyc();
        chk("t2_fcount2", 32'(dut.fcount),   32'd2);
        chk("t2_ov",      32'(bus.out_valid), 32'd1);
        chk("t2_head",    32'(bus.out_data),  32'h0002);
        bus.in_data  = 16'hFFFE;
        bus.in_valid = 1'b1;
        repeat (8) begin
            cyc();
            chk("t2_stall_rdy", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        cyc();
        chk("t2_second",  32'(bus.out_data), 32'h0101);
        chk("t2_rdy_up",  32'(bus.in_ready), 32'd1);
        cyc();
        bus.in_valid = 1'b0;
        chk("t2_empty",    32'(bus.out_valid), 32'd0);
        chk("t2_kick",     32'(bus.eng_start), 32'd1);
        chk("t2_kick_din", 32'(bus.eng_din),   32'hFFFE);
        repeat (6) begin
            cyc();
            chk("t2_wait_ov", 32'(bus.out_valid), 32'd0);
        end
        cyc();
        chk("t2_third_ov", 32'(bus.out_valid), 32'd1);
        chk("t2_third",    32'(bus.out_data),  32'hFFFF);
        cyc();
        chk("t2_drained", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        // 3: push and pop on the same edge keep occupancy and order
        send(16'h0A00, "t3a");
        send(16'h0B00, "t3b");
        repeat (6) cyc();
        chk("t3_head",   32'(bus.out_data), 32'h0A01);
        chk("t3_fcount", 32'(dut.fcount),   32'd1);
        bus.out_ready = 1'b1;
        cyc();
        chk("t3_fcount_same", 32'(dut.fcount),   32'd1);
        chk("t3_ov",          32'(bus.out_valid), 32'd1);
        chk("t3_next",        32'(bus.out_data),  32'h0B01);
        cyc();
        chk("t3_drained", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        // 4: stuck engine -> timeout after 64 WAIT cycles (watchdog 0..63)
        hold_busy = 1'b1;
        send(16'h1234, "t4");
        repeat (65) begin
            chk("t4_err_lo", 32'(bus.err),       32'd0);
            chk("t4_no_push", 32'(bus.out_valid), 32'd0);
            cyc();
        end
        chk("t4_err_hi", 32'(bus.err),       32'd1);
        chk("t4_ov",     32'(bus.out_valid), 32'd0);
        chk("t4_rdy",    32'(bus.in_ready),  32'd0);
        repeat (10) begin
            cyc();
            chk("t4_rdy_hold", 32'(bus.in_ready), 32'd0);
        end
        hold_busy = 1'b0;
        for (int i = 0; i < 20 && !bus.in_ready; i++) cyc();
        chk("t4_rdy_back", 32'(bus.in_ready), 32'd1);
        repeat (5) begin
            cyc();
            chk("t4_stale", 32'(bus.out_valid), 32'd0);
        end

        // 5: clear, then timeout coinciding with clear
        bus.err_clr = 1'b1;
        cyc();
        bus.err_clr = 1'b0;
        chk("t5_cleared", 32'(bus.err), 32'd0);
        hold_busy = 1'b1;
        send(16'h2222, "t5");
        repeat (64) cyc();
        chk("t5_pre", 32'(bus.err), 32'd0);
        bus.err_clr = 1'b1;
        cyc();
        chk("t5_set_wins", 32'(bus.err), 32'd1);
        cyc();
        chk("t5_clr", 32'(bus.err), 32'd0);
        bus.err_clr = 1'b0;
        hold_busy = 1'b0;
        for (int i = 0; i < 20 && !bus.in_ready; i++) cyc();
        chk("t5_rdy_back", 32'(bus.in_ready), 32'd1);

        // 6: reset during WAIT with one result queued
        eng_b = 5;
        send(16'h3000, "t6a");
        repeat (7) cyc();
        chk("t6_one", 32'(bus.out_valid), 32'd1);
        send(16'h3100, "t6b");
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_ov",    32'(bus.out_valid), 32'd0);
        chk("t6_data",  32'(bus.out_data),  32'd0);
        chk("t6_start", 32'(bus.eng_start), 32'd0);
        chk("t6_busy_blocks", 32'(bus.in_ready), 32'd0);
        repeat (15) begin
            cyc();
            chk("t6_no_kick", 32'(bus.eng_start), 32'd0);
            chk("t6_no_out",  32'(bus.out_valid), 32'd0);
        end
        chk("t6_idle_rdy", 32'(bus.in_ready), 32'd1);

        // Random traffic against a result queue
        for (int c = 0; c < 1500; c++) begin
            cyc();
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.in_data   = 16'($urandom);
            eng_b         = $urandom_range(1, 8);
            if (bus.in_valid && bus.in_ready) begin
                chk("rnd_room", 32'(expq.size() < 2), 32'd1);
                expq.push_back(bus.in_data + 16'd1);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) chk("rnd_unexpected", 32'(bus.out_valid), 32'd0);
                else chk("rnd_data", 32'(bus.out_data), 32'(expq.pop_front()));
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            cyc();
            if (bus.out_valid) begin
                if (expq.size() == 0) chk("drain_unexpected", 32'(bus.out_valid), 32'd0);
                else chk("drain_data", 32'(bus.out_data), 32'(expq.pop_front()));
            end
        end
        chk("drain_empty", 32'(expq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
